// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, defaults and frame-length helper for spi_master_multi
package spi_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DVSR_W = 16;
    localparam int DEF_NUM_SS = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPHA_DLY = 3'd1,
        P0       = 3'd2,
        P1       = 3'd3,
        DONE     = 3'd4
    } state_e;

    // Cycles from the accepting clock cycle to the cycle carrying the done tick.
    function automatic int frame_cycles(input int data_w, input int dvsr, input logic cpha);
        if (cpha)
            return (2 * data_w + 1) * (dvsr + 1) + 1;
        return 2 * data_w * (dvsr + 1) + 1;
    endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// rtl/spi_master_multi_if.sv - control-side request/response bundle of spi_master_multi
interface spi_master_multi_if #(
    parameter int DATA_W = 8,
    parameter int DVSR_W = 16,
    parameter int SS_W   = 2
);
    logic [DATA_W-1:0] din_i;
    logic [DVSR_W-1:0] dvsr_i;
    logic              start_i;
    logic              cpol_i;
    logic              cpha_i;
    logic [SS_W-1:0]   ss_sel_i;
    logic [DATA_W-1:0] dout_o;
    logic              ready_o;
    logic              spi_done_tick_o;

    modport master (
        output din_i, dvsr_i, start_i, cpol_i, cpha_i, ss_sel_i,
        input  dout_o, ready_o, spi_done_tick_o
    );

    modport slave (
        input  din_i, dvsr_i, start_i, cpol_i, cpha_i, ss_sel_i,
        output dout_o, ready_o, spi_done_tick_o
    );
endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period counter; half_tick_o marks the last cycle of each half period
module spi_clk_div #(
    parameter int DVSR_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              half_tick_o
);
    logic [DVSR_W-1:0] cnt_q;

    // Equality compare at full width: the counter wraps to 0 before it can overflow.
    assign half_tick_o = en_i && (cnt_q == dvsr_i);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            cnt_q <= '0;
        else if (clr_i || half_tick_o)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= cnt_q + DVSR_W'(1);
    end
endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - multi-slave SPI master, all CPOL/CPHA modes; SPI_MASTER_LSB_FIRST_EN adds lsb_first_i
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DVSR_W = DEF_DVSR_W,
    parameter int NUM_SS = DEF_NUM_SS,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    spi_master_multi_if.slave bus,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first_i,
`endif
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [NUM_SS-1:0] ss_n_o
);
    localparam int BIT_W = $clog2(DATA_W);

    state_e            state_q, state_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [SS_W-1:0]   ss_sel_q, ss_sel_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, ready_q, ready_d, done_q, done_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic              lsb_in, half_tick, accept, active_d, phase_d;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first_i;
`else
    assign lsb_in = 1'b0;
`endif

    assign accept = (state_q == IDLE) && bus.start_i;

    spi_clk_div #(.DVSR_W(DVSR_W)) u_clk_div (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .clr_i       (accept),
        .en_i        ((state_q == CPHA_DLY) || (state_q == P0) || (state_q == P1)),
        .dvsr_i      (dvsr_q),
        .half_tick_o (half_tick)
    );

    always_comb begin
        state_d  = state_q;
        dvsr_d   = dvsr_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        ss_sel_d = ss_sel_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        dout_d   = dout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    dvsr_d   = bus.dvsr_i;
                    cpol_d   = bus.cpol_i;
                    cpha_d   = bus.cpha_i;
                    lsb_d    = lsb_in;
                    ss_sel_d = bus.ss_sel_i;
                    tx_d     = bus.din_i;
                    rx_d     = '0;
                    bit_d    = '0;
                    state_d  = bus.cpha_i ? CPHA_DLY : P0;
                end
            end
            CPHA_DLY: if (half_tick) state_d = P0;
            P0: begin
                if (half_tick) begin
                    rx_d    = lsb_q ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
                    state_d = P1;
                end
            end
            P1: begin
                if (half_tick) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        dout_d  = rx_q;
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                        state_d = P0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin outputs are derived from the next state so they register in step with it.
        active_d = (state_d == CPHA_DLY) || (state_d == P0) || (state_d == P1);
        phase_d  = ((state_d == P1) && !cpha_d) || ((state_d == P0) && cpha_d);
        sclk_d   = phase_d ^ cpol_d;
        mosi_d   = active_d ? (lsb_d ? tx_d[0] : tx_d[DATA_W-1]) : 1'b0;
        ss_n_d   = active_d ? ~(NUM_SS'(1) << ss_sel_d) : '1;
        ready_d  = (state_d == IDLE) || (state_d == DONE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            dvsr_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            ss_sel_q <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            bit_q    <= '0;
            dout_q   <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ss_n_q   <= '1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dvsr_q   <= dvsr_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            lsb_q    <= lsb_d;
            ss_sel_q <= ss_sel_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            bit_q    <= bit_d;
            dout_q   <= dout_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ss_n_q   <= ss_n_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // While idle the clock pin follows the live polarity input.
    assign sclk_o              = (state_q == IDLE) ? bus.cpol_i : sclk_q;
    assign mosi_o              = mosi_q;
    assign ss_n_o              = ss_n_q;
    assign bus.dout_o          = dout_q;
    assign bus.ready_o         = ready_q;
    assign bus.spi_done_tick_o = done_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - self-checking bench for spi_master_multi with a behavioural SPI slave
module tb_spi_master_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt_a = 0;

    spi_master_multi_if #(.DATA_W(8),  .DVSR_W(16), .SS_W(2)) bus_a ();
    spi_master_multi_if #(.DATA_W(16), .DVSR_W(16), .SS_W(2)) bus_b ();

    logic       miso_a = 1'b0, sclk_a, mosi_a;
    logic [3:0] ss_a;
    logic       miso_b = 1'b0, sclk_b, mosi_b;
    logic [2:0] ss_b;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_a = 1'b0;
    logic lsb_b = 1'b0;
`endif

    spi_master_multi #(.DATA_W(8), .DVSR_W(16), .NUM_SS(4), .SS_W(2)) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .bus(bus_a),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first_i(lsb_a),
`endif
        .miso_i(miso_a), .sclk_o(sclk_a), .mosi_o(mosi_a), .ss_n_o(ss_a)
    );

    spi_master_multi #(.DATA_W(16), .DVSR_W(16), .NUM_SS(3), .SS_W(2)) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .bus(bus_b),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first_i(lsb_b),
`endif
        .miso_i(miso_b), .sclk_o(sclk_b), .mosi_o(mosi_b), .ss_n_o(ss_b)
    );

    always @(negedge clk) if (bus_a.spi_done_tick_o) done_cnt_a++;

    // Behavioural slave: edges counted from select assertion; even = leading, odd = trailing.
    logic [7:0] slv_word = 8'h00, slv_cap = 8'h00;
    logic       slv_cpha = 1'b0, prev_act = 1'b0, prev_sclk = 1'b0;
    int         edge_k = 0, out_i = 0;
    wire        ss_act_a = ~&ss_a;

    always @(ss_act_a or sclk_a) begin
        if (ss_act_a && !prev_act) begin
            edge_k = 0; out_i = 0; slv_cap = 8'h00;
            if (!slv_cpha) begin miso_a = slv_word[7]; out_i = 1; end
        end else if (ss_act_a && (sclk_a !== prev_sclk)) begin
            if (((edge_k % 2) == 0) == !slv_cpha)
                slv_cap = {slv_cap[6:0], mosi_a};
            else if (out_i < 8) begin
                miso_a = slv_word[7 - out_i];
                out_i++;
            end
            edge_k++;
        end else if (!ss_act_a)
            miso_a = 1'b0;
        prev_act = ss_act_a;
        prev_sclk = sclk_a;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge in IDLE; poke>0 also pulses start mid-frame and in the DONE cycle.
    task automatic frame_a(input string tag, input logic [7:0] din, input logic [7:0] mw,
                           input int dvsr, input logic cpol, input logic cpha,
                           input logic [1:0] sel, input int poke, output int lat);
        int ss_bad, dc0;
        logic [3:0] exp_ss;
        exp_ss = 4'hF;
        exp_ss[sel] = 1'b0;
        ss_bad = 0;
        bus_a.cpol_i = cpol; bus_a.cpha_i = cpha;
        slv_word = mw; slv_cpha = cpha;
        #1;
        check({tag, "/idle_sclk"}, sclk_a, cpol);
        bus_a.din_i = din; bus_a.dvsr_i = dvsr[15:0]; bus_a.ss_sel_i = sel; bus_a.start_i = 1'b1;
        dc0 = done_cnt_a;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        lat = 1;
        check({tag, "/ready_drop"}, bus_a.ready_o, 1'b0);
        while (!bus_a.spi_done_tick_o && lat < 3000) begin
            if (ss_a !== exp_ss) ss_bad++;
            bus_a.start_i = (poke > 0 && lat == poke);
            @(negedge clk);
            lat++;
        end
        check({tag, "/lat"}, lat, spi_pkg::frame_cycles(8, dvsr, cpha));
        check({tag, "/dout"}, bus_a.dout_o, mw);
        check({tag, "/mosi_word"}, slv_cap, din);
        check({tag, "/ss_frame_bad"}, ss_bad, 0);
        check({tag, "/ss_done"}, ss_a, 4'hF);
        check({tag, "/ready_done"}, bus_a.ready_o, 1'b1);
        bus_a.start_i = (poke > 0);
        @(negedge clk);
        bus_a.start_i = 1'b0;
        check({tag, "/tick_1cyc"}, bus_a.spi_done_tick_o, 1'b0);
        check({tag, "/done_cnt"}, done_cnt_a, dc0 + 1);
        check({tag, "/dout_hold"}, bus_a.dout_o, mw);
        check({tag, "/idle_after"}, ss_a, 4'hF);
    endtask

    task automatic frame_b(input string tag, input logic miso, input int dvsr, input logic cpha,
                           input logic [1:0] sel, input logic [2:0] exp_ss, input int exp_lat);
        int lat, edges, ss_bad, mosi_bad;
        logic prev;
        miso_b = miso;
        bus_b.cpol_i = 1'b0; bus_b.cpha_i = cpha; bus_b.din_i = 16'hFFFF;
        bus_b.dvsr_i = dvsr[15:0]; bus_b.ss_sel_i = sel; bus_b.start_i = 1'b1;
        @(negedge clk);
        bus_b.start_i = 1'b0;
        lat = 1; edges = 0; ss_bad = 0; mosi_bad = 0; prev = sclk_b;
        while (!bus_b.spi_done_tick_o && lat < 3000) begin
            if (ss_b !== exp_ss) ss_bad++;
            if (mosi_b !== 1'b1) mosi_bad++;
            @(negedge clk);
            lat++;
            if (sclk_b !== prev) edges++;
            prev = sclk_b;
        end
        check({tag, "/lat"}, lat, exp_lat);
        check({tag, "/dout"}, bus_b.dout_o, miso ? 16'hFFFF : 16'h0000);
        check({tag, "/sclk_edges"}, edges, 32);
        check({tag, "/ss_bad"}, ss_bad, 0);
        check({tag, "/mosi_bad"}, mosi_bad, 0);
        @(negedge clk);
    endtask

    initial begin
        int lat, dc0;
        logic [7:0] rd, rm;
        bus_a.din_i = '0; bus_a.dvsr_i = '0; bus_a.start_i = 1'b0;
        bus_a.cpol_i = 1'b0; bus_a.cpha_i = 1'b0; bus_a.ss_sel_i = '0;
        bus_b.din_i = '0; bus_b.dvsr_i = '0; bus_b.start_i = 1'b0;
        bus_b.cpol_i = 1'b0; bus_b.cpha_i = 1'b0; bus_b.ss_sel_i = '0;

        repeat (2) @(negedge clk);
        check("rst/ready", bus_a.ready_o, 1'b1);
        check("rst/done", bus_a.spi_done_tick_o, 1'b0);
        check("rst/dout", bus_a.dout_o, 8'h00);
        check("rst/ss", ss_a, 4'hF);
        check("rst/sclk", sclk_a, 1'b0);
        check("rst/mosi", mosi_a, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        frame_a("t1", 8'hA5, 8'h3C, 9, 1'b0, 1'b0, 2'd2, 0, lat);
        check("t1/lat161", lat, 161);

        for (int m = 0; m < 4; m++) begin
            frame_a($sformatf("t2m%0d", m), 8'h81, 8'h7E, 3, m[1], m[0], m[0] ? 2'd3 : 2'd2, 0, lat);
            if (m[0]) check($sformatf("t2m%0d/lat69", m), lat, 69);
        end

        frame_a("t4", 8'h5A, 8'hC3, 2, 1'b1, 1'b0, 2'd1, 20, lat);
        frame_a("t4next", 8'h96, 8'h69, 1, 1'b0, 1'b1, 2'd0, 0, lat);

        bus_a.cpol_i = 1'b0; bus_a.cpha_i = 1'b0; bus_a.din_i = 8'hC3;
        bus_a.dvsr_i = 16'd3; bus_a.ss_sel_i = 2'd1; slv_word = 8'h99; slv_cpha = 1'b0;
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        dc0 = done_cnt_a;
        repeat (34) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5/ready", bus_a.ready_o, 1'b1);
        check("t5/ss", ss_a, 4'hF);
        check("t5/sclk", sclk_a, 1'b0);
        check("t5/mosi", mosi_a, 1'b0);
        check("t5/dout", bus_a.dout_o, 8'h00);
        check("t5/done", bus_a.spi_done_tick_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5/no_tick", done_cnt_a, dc0);
        frame_a("t5after", 8'h3E, 8'hE3, 4, 1'b0, 1'b0, 2'd3, 0, lat);

        frame_b("t6", 1'b0, 0, 1'b0, 2'd3, 3'b111, 33);
        frame_b("t6b", 1'b1, 2, 1'b1, 2'd0, 3'b110, spi_pkg::frame_cycles(16, 2, 1'b1));

        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            rm = 8'($urandom);
            frame_a($sformatf("rnd%0d", i), rd, rm, $urandom_range(0, 4),
                    1'($urandom), 1'($urandom), 2'($urandom), 0, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
